// File: rtl/instr_fetch_sequencer_if.sv
// Handshake/bus bundle between the fetch sequencer and its PC, ROM and execute stage.
interface instr_fetch_sequencer_if;
    logic       start;
    logic [7:0] rom_data;
    logic       instr_ready;
    logic       zero_flag;
    logic       pc_rd_en;
    logic       pc_inc;
    logic       load_pc;
    logic [7:0] pc_in;
    logic       rom_rd_en;
    logic [7:0] instr;
    logic       instr_valid;
    logic       halted;

    modport master (
        input  start, rom_data, instr_ready, zero_flag,
        output pc_rd_en, pc_inc, load_pc, pc_in, rom_rd_en, instr, instr_valid, halted
    );
    modport slave (
        output start, rom_data, instr_ready, zero_flag,
        input  pc_rd_en, pc_inc, load_pc, pc_in, rom_rd_en, instr, instr_valid, halted
    );
endinterface

// File: rtl/instr_fetch_sequencer.sv
// Fetch/decode sequencer for an 8-bit PC + sync ROM; resolves NOP/JMP/HLT locally and issues the rest.
// Optional FETCH_COND_JZ_EN adds opcode 4'hD as a two-byte jump-if-zero.
module instr_fetch_sequencer (
    input  logic                     clk,
    input  logic                     reset_n,
    instr_fetch_sequencer_if.master  bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_WAIT, S_DECODE, S_FETCH_OP,
        S_WAIT_OP, S_LOAD, S_ISSUE, S_HALT
    } state_e;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_JZ  = 4'hD;
    localparam logic [3:0] OP_JMP = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_e     state_q, state_d;
    logic [7:0] ir_q, target_q;
    logic [3:0] op;
    logic       is_jmp, is_jz, take_jump;

    assign op     = ir_q[7:4];
    assign is_jmp = (op == OP_JMP);

`ifdef FETCH_COND_JZ_EN
    assign is_jz     = (op == OP_JZ);
    assign take_jump = is_jmp || (is_jz && bus.zero_flag);
`else
    logic unused_zero_flag;
    assign unused_zero_flag = bus.zero_flag;
    assign is_jz     = 1'b0;
    assign take_jump = is_jmp;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Sync ROM data is valid in the cycle after the read strobe, i.e. in WAIT/WAIT_OP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_q     <= 8'h00;
            target_q <= 8'h00;
        end else begin
            if (state_q == S_WAIT)    ir_q     <= bus.rom_data;
            if (state_q == S_WAIT_OP) target_q <= bus.rom_data;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (bus.start) state_d = S_FETCH;
            S_FETCH:    state_d = S_WAIT;
            S_WAIT:     state_d = S_DECODE;
            S_DECODE: begin
                if (op == OP_NOP)         state_d = S_FETCH;
                else if (op == OP_HLT)    state_d = S_HALT;
                else if (is_jmp || is_jz) state_d = S_FETCH_OP;
                else                      state_d = S_ISSUE;
            end
            S_FETCH_OP: state_d = S_WAIT_OP;
            S_WAIT_OP:  state_d = take_jump ? S_LOAD : S_FETCH;
            S_LOAD:     state_d = S_FETCH;
            S_ISSUE:    if (bus.instr_ready) state_d = S_FETCH;
            S_HALT:     if (bus.start) state_d = S_FETCH;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.pc_rd_en    = 1'b0;
        bus.rom_rd_en   = 1'b0;
        bus.pc_inc      = 1'b0;
        bus.load_pc     = 1'b0;
        bus.instr_valid = 1'b0;
        bus.halted      = 1'b0;
        case (state_q)
            S_FETCH, S_FETCH_OP: begin
                bus.pc_rd_en  = 1'b1;
                bus.rom_rd_en = 1'b1;
            end
            S_WAIT, S_WAIT_OP: bus.pc_inc      = 1'b1;
            S_LOAD:            bus.load_pc     = 1'b1;
            S_ISSUE:           bus.instr_valid = 1'b1;
            S_HALT:            bus.halted      = 1'b1;
            default: ;
        endcase
    end

    assign bus.instr = ir_q;
    assign bus.pc_in = target_q;
endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Directed bench: PC + sync ROM model around the sequencer, scoreboard queues checked by a monitor.
module tb_instr_fetch_sequencer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    instr_fetch_sequencer_if bus();

    instr_fetch_sequencer dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    logic [7:0] pc, rom_q;
    int         cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)         pc <= 8'h00;
        else if (bus.load_pc) pc <= bus.pc_in;
        else if (bus.pc_inc)  pc <= pc + 8'h01;
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)           rom_q <= 8'h00;
        else if (bus.rom_rd_en) rom_q <= mem[pc];
    end
    assign bus.rom_data = rom_q;

    logic [7:0] exp_instr[$];
    logic [7:0] exp_load[$];
    int total = 0, bad = 0;
    int pcinc_cnt = 0, load_cnt = 0;
    int s;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [21:0] outs();
        return {bus.pc_rd_en, bus.pc_inc, bus.load_pc, bus.pc_in, bus.rom_rd_en,
                bus.instr, bus.instr_valid, bus.halted};
    endfunction

    task automatic monitor();
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (bus.pc_inc) pcinc_cnt++;
                chk("inc_and_load", {31'd0, bus.pc_inc & bus.load_pc}, 32'd0);
                if (bus.load_pc) begin
                    load_cnt++;
                    if (exp_load.size() == 0) chk("load_unexpected", {24'd0, bus.pc_in}, 32'hFFFF);
                    else begin e = exp_load.pop_front(); chk("pc_in", {24'd0, bus.pc_in}, {24'd0, e}); end
                end
                if (bus.instr_valid && bus.instr_ready) begin
                    if (exp_instr.size() == 0) chk("instr_unexpected", {24'd0, bus.instr}, 32'hFFFF);
                    else begin e = exp_instr.pop_front(); chk("instr", {24'd0, bus.instr}, {24'd0, e}); end
                end
            end
        end
    endtask

    task automatic load_rom();
        for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1 chk("reset_outs", {10'd0, outs()}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        pcinc_cnt = 0;
        load_cnt = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        bus.start = 1'b1;
        s = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // which: 0 = instr_valid, 1 = halted
    task automatic wait_for(input int which, input string name);
        int n = 0;
        logic hit;
        do begin
            @(negedge clk);
            n++;
            hit = (which == 0) ? bus.instr_valid : bus.halted;
        end while (!hit && n < 60);
        if (!hit) begin
            total++; bad++;
            $display("FAIL timeout_%s: got 0 want 1", name);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.instr_ready = 1'b1;
        bus.zero_flag = 1'b0;
        fork monitor(); join_none

        // NOP then issued instruction
        load_rom(); mem[0] = 8'h00; mem[1] = 8'h35;
        do_reset();
        @(negedge clk) chk("idle_outs", {10'd0, outs()}, 32'd0);
        exp_instr.push_back(8'h35);
        pulse_start();
        wait_for(0, "nop_issue");
        chk("issue_latency", cyc - s, 32'd7);
        chk("pc_inc_count", pcinc_cnt, 32'd2);
        wait_for(1, "nop_halt");
        chk("drained_nop", exp_instr.size(), 32'd0);

        // JMP
        load_rom(); mem[0] = 8'hE0; mem[1] = 8'h80; mem[8'h80] = 8'h12;
        do_reset();
        exp_load.push_back(8'h80);
        exp_instr.push_back(8'h12);
        pulse_start();
        wait_for(1, "jmp_halt");
        chk("load_cycles", load_cnt, 32'd1);
        chk("drained_jmp", exp_instr.size() + exp_load.size(), 32'd0);

        // Backpressure
        load_rom(); mem[0] = 8'h35;
        do_reset();
        bus.instr_ready = 1'b0;
        pulse_start();
        wait_for(0, "bp_issue");
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold", {bus.instr_valid, bus.instr, bus.pc_rd_en, bus.pc_inc, bus.rom_rd_en},
                {1'b1, 8'h35, 3'b000});
            @(negedge clk);
        end
        exp_instr.push_back(8'h35);
        @(posedge clk); #1 bus.instr_ready = 1'b1;
        @(negedge clk);
        @(negedge clk) chk("bp_refetch", {31'd0, bus.pc_rd_en}, 32'd1);
        wait_for(1, "bp_halt");
        chk("drained_bp", exp_instr.size(), 32'd0);

        // HLT and resume
        load_rom(); mem[0] = 8'hF0; mem[1] = 8'h21;
        do_reset();
        pulse_start();
        wait_for(1, "hlt");
        chk("halted_latency", cyc - s, 32'd4);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("halt_quiet", {bus.halted, bus.pc_rd_en, bus.pc_inc, bus.load_pc, bus.rom_rd_en, bus.instr_valid},
                {1'b1, 5'b0});
        end
        exp_instr.push_back(8'h21);
        pulse_start();
        wait_for(0, "resume_issue");
        chk("resume_not_halted", {31'd0, bus.halted}, 32'd0);
        wait_for(1, "resume_halt");
        chk("drained_hlt", exp_instr.size(), 32'd0);

        // JZ
`ifdef FETCH_COND_JZ_EN
        load_rom(); mem[0] = 8'hD0; mem[1] = 8'h40; mem[2] = 8'h55; mem[8'h40] = 8'h66;
        do_reset();
        bus.zero_flag = 1'b0;
        exp_instr.push_back(8'h55);
        pulse_start();
        wait_for(1, "jz_nt_halt");
        chk("jz_nt_no_load", load_cnt, 32'd0);
        do_reset();
        bus.zero_flag = 1'b1;
        exp_load.push_back(8'h40);
        exp_instr.push_back(8'h66);
        pulse_start();
        wait_for(1, "jz_t_halt");
        chk("jz_t_load", load_cnt, 32'd1);
        bus.zero_flag = 1'b0;
`else
        load_rom(); mem[0] = 8'hD0; mem[1] = 8'h40;
        do_reset();
        bus.zero_flag = 1'b1;
        exp_instr.push_back(8'hD0);
        exp_instr.push_back(8'h40);
        pulse_start();
        wait_for(1, "d0_halt");
        chk("d0_no_load", load_cnt, 32'd0);
        bus.zero_flag = 1'b0;
`endif
        chk("drained_jz", exp_instr.size() + exp_load.size(), 32'd0);

        // Async reset mid-ISSUE
        load_rom(); mem[0] = 8'h35;
        do_reset();
        bus.instr_ready = 1'b0;
        pulse_start();
        wait_for(0, "rst_issue");
        #1 reset_n = 1'b0;
        #1 chk("rst_issue_outs", {10'd0, outs()}, 32'd0);
        @(negedge clk) reset_n = 1'b1;
        bus.instr_ready = 1'b1;
        repeat (3) @(negedge clk) chk("rst_idle", {10'd0, outs()}, 32'd0);

        // Async reset mid-WAIT_OP
        load_rom(); mem[0] = 8'hE0; mem[1] = 8'h80;
        do_reset();
        pulse_start();
        repeat (4) @(posedge clk);
        @(negedge clk) chk("in_wait_op", {31'd0, bus.pc_inc}, 32'd1);
        #1 reset_n = 1'b0;
        #1 chk("rst_waitop_outs", {10'd0, outs()}, 32'd0);
        @(negedge clk) reset_n = 1'b1;
        repeat (3) @(negedge clk) chk("rst_idle2", {10'd0, outs()}, 32'd0);
        chk("drained_end", exp_instr.size() + exp_load.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_fetch_sequencer.md
# instr_fetch_sequencer

Control-side initiator for the 8-bit program address counter: drives its `pc_inc`, `load_pc` and `pc_rd_en` strobes and its `pc_in` jump target. It fetches bytes from a synchronous program ROM addressed by the PC output. It decodes only control-flow opcodes (NOP, JMP, HLT, optional JZ) and hands every other instruction to the execute stage over a valid/ready handshake. It sits between the PC/ROM pair and the datapath controller.

## Interface
- No parameters; address and instruction widths are fixed at 8 bits.
- `clk` input 1: single clock, all state on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle pulse; leaves IDLE or HALT.
- `rom_data` input 8: sync-ROM read data, valid the cycle after `rom_rd_en`.
- `instr_ready` input 1: execute stage accepts `instr`.
- `zero_flag` input 1: datapath Z flag (used only with JZ configuration).
- `pc_rd_en` output 1: PC drives address onto ROM address bus.
- `pc_inc` output 1: PC increments at the next edge.
- `load_pc` output 1: PC loads `pc_in` at the next edge.
- `pc_in` output 8: jump target to PC.
- `rom_rd_en` output 1: ROM read strobe.
- `instr` output 8: issued instruction.
- `instr_valid` output 1: `instr` is valid.
- `halted` output 1: sequencer is in HALT.

## Operation
- Opcode is `ir[7:4]`. Opcodes: 4'h0 NOP, 4'hE JMP (two bytes; the second byte is the target), 4'hF HLT, 4'hD JZ (two bytes; only with `FETCH_COND_JZ_EN`). All other opcodes are issued.
- States:
  - IDLE: on `start`, go to FETCH.
  - FETCH: `pc_rd_en`=1, `rom_rd_en`=1. Go to WAIT.
  - WAIT: `pc_inc`=1; `ir` <= `rom_data`. Go to DECODE.
  - DECODE: next state by opcode:
    - NOP: go to FETCH.
    - HLT: go to HALT.
    - JMP or JZ: go to FETCH_OP.
    - Otherwise: go to ISSUE.
  - FETCH_OP: `pc_rd_en`=1, `rom_rd_en`=1. Go to WAIT_OP.
  - WAIT_OP: `pc_inc`=1; `target` <= `rom_data`. Next state:
    - JMP: go to LOAD.
    - JZ with `zero_flag`=1 (sampled in WAIT_OP): go to LOAD.
    - JZ with `zero_flag`=0: go to FETCH.
  - LOAD: `load_pc`=1. Go to FETCH.
  - ISSUE: `instr_valid`=1, `instr`=`ir`. Leave for FETCH on the edge where `instr_ready`=1; otherwise hold.
  - HALT: `halted`=1. On `start`, go to FETCH and resume at the current PC (byte after HLT).
- `pc_in` is driven continuously from the `target` register.
- Invariants:
  - `pc_inc` and `load_pc` are never high in the same cycle.
  - `pc_rd_en` is high only in FETCH and FETCH_OP.
  - `start` is ignored outside IDLE and HALT.
- Handshake rules:
  - `instr_valid` never drops before `instr_ready` is seen.
  - `instr` is stable while `instr_valid`=1.
  - `instr_ready` outside ISSUE is ignored.
- PC wrap (8'hFF to 8'h00) is handled by the PC. The sequencer needs no special handling; a JMP operand at address 8'h00 after wrap is fetched normally.

## Timing
- Reset (async assert, sync-released usage):
  - State goes to IDLE.
  - `ir`, `target`, `instr` = 8'h00.
  - All 1-bit outputs = 0.
  - Reset mid-ISSUE drops `instr_valid` immediately.
- Latencies, counted from the cycle FETCH is entered:
  - NOP: 3 cycles per fetch.
  - Issued instruction: `instr_valid` rises in cycle 4; at 1 cycle per handshake, total is 4 cycles.
  - JMP: 6 cycles from FETCH to the next FETCH. The PC holds the target in the first cycle of the next FETCH.
  - JZ not taken: 5 cycles.
  - HLT: `halted` rises in cycle 4.
- `start` in IDLE: FETCH begins the next cycle.

## Configuration
- `FETCH_COND_JZ_EN` defined: opcode 4'hD is a two-byte conditional jump on `zero_flag` (sampled in WAIT_OP).
- `FETCH_COND_JZ_EN` undefined: 4'hD is an ordinary issued instruction, and `zero_flag` is unused.

## Test plan
- Reset, then `start`:
  - ROM[0]=8'h00 (NOP), ROM[1]=8'h35.
  - Required: `instr`=8'h35 with `instr_valid` at cycle 7 after `start`.
  - Required: `pc_inc` pulses exactly twice.
- JMP:
  - ROM[0]=8'hE0, ROM[1]=8'h80, ROM[8'h80]=8'h12.
  - Required: `load_pc`=1 with `pc_in`=8'h80 for one cycle.
  - Required: the next issued `instr`=8'h12.
- Backpressure:
  - Hold `instr_ready`=0 for 5 cycles in ISSUE.
  - Required: `instr_valid` and `instr` stable for those cycles.
  - Required: no `pc_rd_en`/`pc_inc` until the ready cycle.
- HLT:
  - ROM[0]=8'hF0, ROM[1]=8'h21.
  - Required: `halted`=1, with no strobes for 10 cycles.
  - Then `start`: required `instr`=8'h21 and `halted`=0.
- JZ (with `FETCH_COND_JZ_EN`):
  - ROM[0]=8'hD0, ROM[1]=8'h40.
  - `zero_flag`=0: required no `load_pc`; next fetch is from 8'h02.
  - `zero_flag`=1: required `load_pc` with `pc_in`=8'h40.
  - Without the macro: required `instr`=8'hD0 issued.
- Async reset:
  - Assert `reset_n`=0 mid-ISSUE and mid-WAIT_OP.
  - Required: all outputs 0 within the same cycle.
  - Required: state IDLE after release.
